usb_host_xfer: RTL and testbench

- Host-side transaction initiator: the opposite end of the device-side protocol stack.
- Takes one command (SETUP/OUT/IN, address, endpoint, toggle) and drives `encode_packet` token/data/handshake requests.
- Consumes `decode_packet` handshake/data outputs, applies the turnaround timeout, and returns one response per command.
- Sits between a host test/controller FSM and the ULPI-facing encoder/decoder pair.

---
 rtl/usb_host_xfer_pkg.sv | 51 +++++
 rtl/usb_host_xfer_timer.sv | 28 ++
 rtl/usb_host_xfer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_usb_host_xfer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_host_xfer_pkg.sv
// Shared encodings for the host transaction initiator: token/data/handshake PIDs,
// response codes and FSM states.
package usb_host_xfer_pkg;

  localparam logic [1:0] PidOut      = 2'b00;
  localparam logic [1:0] PidReserved = 2'b01;
  localparam logic [1:0] PidIn       = 2'b10;
  localparam logic [1:0] PidSetup    = 2'b11;

  localparam logic [1:0] PidData0 = 2'b00;
  localparam logic [1:0] PidData1 = 2'b10;

  localparam logic [1:0] HskAck   = 2'b00;
  localparam logic [1:0] HskNyet  = 2'b01;
  localparam logic [1:0] HskNak   = 2'b10;
  localparam logic [1:0] HskStall = 2'b11;

  typedef enum logic [2:0] {
    RspAck     = 3'd0,
    RspNak     = 3'd1,
    RspStall   = 3'd2,
    RspNyet    = 3'd3,
    RspTimeout = 3'd4,
    RspCrcErr  = 3'd5,
    RspDataSeq = 3'd6,
    RspBadCmd  = 3'd7
  } rsp_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StToken,
    StDataTx,
    StWaitHsk,
    StWaitData,
    StRxData,
    StSendAck,
    StResp
  } xfer_state_e;

  function automatic rsp_code_e hsk_to_rsp(logic [1:0] pid);
    rsp_code_e code;
    unique case (pid)
      HskAck:   code = RspAck;
      HskNak:   code = RspNak;
      HskStall: code = RspStall;
      default:  code = RspNyet;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/usb_host_xfer_timer.sv
// Turnaround timer: cleared at the end of our own packet, counts waiting cycles.
module usb_host_xfer_timer #(
  parameter int unsigned TIMEOUT = 480,
  parameter int unsigned TBITS   = 9
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TBITS-1:0] cnt_q;

  // Fires on the TIMEOUT-th waiting cycle so RESP lands TIMEOUT cycles after the packet end.
  assign expired_o = (cnt_q == TBITS'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/usb_host_xfer.sv
// Host-side USB transaction initiator: issues token, data and ACK requests to the encoder,
// watches decoder replies with a turnaround timeout and returns one response per command.
module usb_host_xfer
  import usb_host_xfer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 480,
  parameter int unsigned TBITS   = 9,
  parameter int unsigned LBITS   = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_type_i,
  input  logic [6:0]       cmd_addr_i,
  input  logic [3:0]       cmd_endp_i,
  input  logic             cmd_toggle_i,
  output logic             rsp_valid_o,
  output logic [2:0]       rsp_code_o,
  output logic [LBITS-1:0] rsp_len_o,
  output logic             tok_send_o,
  input  logic             tok_done_i,
  output logic [1:0]       tok_type_o,
  output logic [15:0]      tok_data_o,
  output logic             trn_tsend_o,
  output logic [1:0]       trn_ttype_o,
  input  logic             trn_tdone_i,
  output logic             hsk_send_o,
  output logic [1:0]       hsk_type_o,
  input  logic             hsk_done_i,
  input  logic             hsk_recv_i,
  input  logic [1:0]       hsk_rtype_i,
  input  logic             dat_recv_i,
  input  logic [1:0]       dat_rtype_i,
  input  logic             crc_err_i,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [7:0]       s_tdata,
  output logic             e_tvalid,
  input  logic             e_tready,
  output logic             e_tlast,
  output logic [7:0]       e_tdata,
  input  logic             d_tvalid,
  output logic             d_tready,
  input  logic             d_tlast,
  input  logic [7:0]       d_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [7:0]       m_tdata
);

  xfer_state_e      state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       endp_q, endp_d;
  logic             toggle_q, toggle_d;
  logic [LBITS-1:0] cnt_q, cnt_d, cnt_inc;
  rsp_code_e        rsp_code_q, rsp_code_d;
  logic [LBITS-1:0] rsp_len_q, rsp_len_d;
  logic             seq_ok_q, seq_ok_d;
  logic             crc_seen_q, crc_seen_d;
  logic             tx_first_q, tx_first_d;
  logic             rx_done_q, rx_done_d;
  logic             timer_clr, timer_en, timer_expired;
  logic [1:0]       data_pid;

  usb_host_xfer_timer #(
    .TIMEOUT(TIMEOUT),
    .TBITS  (TBITS)
  ) u_timer (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expired_o(timer_expired)
  );

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign data_pid    = toggle_q ? PidData1 : PidData0;
  assign tok_type_o  = type_q;
  assign tok_data_o  = {5'b0, endp_q, addr_q};
  assign trn_ttype_o = data_pid;
  assign hsk_type_o  = HskAck;
  assign e_tdata     = s_tdata;
  assign e_tlast     = s_tlast;
  assign m_tdata     = d_tdata;
  assign m_tlast     = d_tlast;
  assign rsp_code_o  = rsp_code_q;
  assign rsp_len_o   = rsp_len_q;

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    toggle_d    = toggle_q;
    cnt_d       = cnt_q;
    rsp_code_d  = rsp_code_q;
    rsp_len_d   = rsp_len_q;
    seq_ok_d    = seq_ok_q;
    crc_seen_d  = crc_seen_q;
    tx_first_d  = 1'b0;
    rx_done_d   = rx_done_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    tok_send_o  = 1'b0;
    trn_tsend_o = 1'b0;
    hsk_send_o  = 1'b0;
    s_tready    = 1'b0;
    e_tvalid    = 1'b0;
    d_tready    = 1'b0;
    m_tvalid    = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gated by reset so the handshake stays low while reset is held.
        cmd_ready_o = reset;
        if (cmd_valid_i && cmd_ready_o) begin
          type_d     = cmd_type_i;
          addr_d     = cmd_addr_i;
          endp_d     = cmd_endp_i;
          toggle_d   = (cmd_type_i == PidSetup) ? 1'b0 : cmd_toggle_i;
          cnt_d      = '0;
          crc_seen_d = 1'b0;
          rx_done_d  = 1'b0;
          if (cmd_type_i == PidReserved) begin
            rsp_code_d = RspBadCmd;
            state_d    = StResp;
          end else begin
            state_d = StToken;
          end
        end
      end
      StToken: begin
        tok_send_o = 1'b1;
        if (tok_done_i) begin
          if (type_q == PidIn) begin
            timer_clr = 1'b1;
            state_d   = StWaitData;
          end else begin
            tx_first_d = 1'b1;
            state_d    = StDataTx;
          end
        end
      end
      StDataTx: begin
        trn_tsend_o = tx_first_q;
        e_tvalid    = s_tvalid;
        s_tready    = e_tready;
        if (s_tvalid && e_tready) cnt_d = cnt_inc;
        if (trn_tdone_i) begin
          timer_clr = 1'b1;
          state_d   = StWaitHsk;
        end
      end
      StWaitHsk: begin
        timer_en = 1'b1;
        if (hsk_recv_i) begin
          rsp_code_d = hsk_to_rsp(hsk_rtype_i);
          state_d    = StResp;
        end else if (timer_expired) begin
          rsp_code_d = RspTimeout;
          state_d    = StResp;
        end
      end
      StWaitData: begin
        timer_en = 1'b1;
        if (hsk_recv_i) begin
          // Only NAK/STALL are legal answers to IN; anything else is a protocol error.
          if (hsk_rtype_i == HskNak || hsk_rtype_i == HskStall) begin
            rsp_code_d = hsk_to_rsp(hsk_rtype_i);
          end else begin
            rsp_code_d = RspTimeout;
          end
          state_d = StResp;
        end else if (dat_recv_i) begin
          seq_ok_d   = (dat_rtype_i == data_pid);
          crc_seen_d = 1'b0;
          rx_done_d  = 1'b0;
          state_d    = StRxData;
        end else if (timer_expired) begin
          rsp_code_d = RspTimeout;
          state_d    = StResp;
        end
      end
      StRxData: begin
        if (!rx_done_q) begin
          m_tvalid = d_tvalid;
          d_tready = m_tready;
          if (crc_err_i) crc_seen_d = 1'b1;
          if (d_tvalid && m_tready) begin
            cnt_d = cnt_inc;
            if (d_tlast) begin
              if (crc_seen_q || crc_err_i) begin
                rsp_code_d = RspCrcErr;
                state_d    = StResp;
              end else begin
                rx_done_d = 1'b1;
              end
            end
          end
        end else begin
          // One-cycle grace after tlast for a late CRC verdict from the decoder.
          if (crc_err_i) begin
            rsp_code_d = RspCrcErr;
            state_d    = StResp;
          end else begin
            state_d = StSendAck;
          end
        end
      end
      StSendAck: begin
        hsk_send_o = 1'b1;
        if (hsk_done_i) begin
          rsp_code_d = seq_ok_q ? RspAck : RspDataSeq;
          state_d    = StResp;
        end
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StResp && state_q != StResp) rsp_len_d = cnt_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      type_q     <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      toggle_q   <= 1'b0;
      cnt_q      <= '0;
      rsp_code_q <= RspAck;
      rsp_len_q  <= '0;
      seq_ok_q   <= 1'b0;
      crc_seen_q <= 1'b0;
      tx_first_q <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      endp_q     <= endp_d;
      toggle_q   <= toggle_d;
      cnt_q      <= cnt_d;
      rsp_code_q <= rsp_code_d;
      rsp_len_q  <= rsp_len_d;
      seq_ok_q   <= seq_ok_d;
      crc_seen_q <= crc_seen_d;
      tx_first_q <= tx_first_d;
      rx_done_q  <= rx_done_d;
    end
  end

endmodule

// File: tb/tb_usb_host_xfer.sv
// Directed bench for usb_host_xfer: the bench plays the encoder, decoder and user streams.
module tb_usb_host_xfer;

  localparam int unsigned TIMEOUT = 480;
  localparam int unsigned TBITS   = 9;
  localparam int unsigned LBITS   = 11;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid_i = 1'b0, cmd_ready_o, cmd_toggle_i = 1'b0;
  logic [1:0]       cmd_type_i = '0;
  logic [6:0]       cmd_addr_i = '0;
  logic [3:0]       cmd_endp_i = '0;
  logic             rsp_valid_o;
  logic [2:0]       rsp_code_o;
  logic [LBITS-1:0] rsp_len_o;
  logic             tok_send_o, tok_done_i = 1'b0;
  logic [1:0]       tok_type_o;
  logic [15:0]      tok_data_o;
  logic             trn_tsend_o, trn_tdone_i = 1'b0;
  logic [1:0]       trn_ttype_o;
  logic             hsk_send_o, hsk_done_i = 1'b0;
  logic [1:0]       hsk_type_o;
  logic             hsk_recv_i = 1'b0;
  logic [1:0]       hsk_rtype_i = '0;
  logic             dat_recv_i = 1'b0, crc_err_i = 1'b0;
  logic [1:0]       dat_rtype_i = '0;
  logic             s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [7:0]       s_tdata = '0;
  logic             e_tvalid, e_tready = 1'b0, e_tlast;
  logic [7:0]       e_tdata;
  logic             d_tvalid = 1'b0, d_tready, d_tlast = 1'b0;
  logic [7:0]       d_tdata = '0;
  logic             m_tvalid, m_tready = 1'b0, m_tlast;
  logic [7:0]       m_tdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] in_bytes [3] = '{8'hAA, 8'hBB, 8'hCC};

  usb_host_xfer #(
    .TIMEOUT(TIMEOUT),
    .TBITS  (TBITS),
    .LBITS  (LBITS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_type_i  (cmd_type_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_endp_i  (cmd_endp_i),
    .cmd_toggle_i(cmd_toggle_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_code_o  (rsp_code_o),
    .rsp_len_o   (rsp_len_o),
    .tok_send_o  (tok_send_o),
    .tok_done_i  (tok_done_i),
    .tok_type_o  (tok_type_o),
    .tok_data_o  (tok_data_o),
    .trn_tsend_o (trn_tsend_o),
    .trn_ttype_o (trn_ttype_o),
    .trn_tdone_i (trn_tdone_i),
    .hsk_send_o  (hsk_send_o),
    .hsk_type_o  (hsk_type_o),
    .hsk_done_i  (hsk_done_i),
    .hsk_recv_i  (hsk_recv_i),
    .hsk_rtype_i (hsk_rtype_i),
    .dat_recv_i  (dat_recv_i),
    .dat_rtype_i (dat_rtype_i),
    .crc_err_i   (crc_err_i),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tdata     (s_tdata),
    .e_tvalid    (e_tvalid),
    .e_tready    (e_tready),
    .e_tlast     (e_tlast),
    .e_tdata     (e_tdata),
    .d_tvalid    (d_tvalid),
    .d_tready    (d_tready),
    .d_tlast     (d_tlast),
    .d_tdata     (d_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tdata     (m_tdata)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a command from IDLE and complete its token phase (one stalled cycle first).
  task automatic start_cmd(input string tag, input logic [1:0] t, input logic [6:0] a,
                           input logic [3:0] e, input logic tg, input logic [15:0] exp_data);
    cmd_valid_i = 1'b1; cmd_type_i = t; cmd_addr_i = a; cmd_endp_i = e; cmd_toggle_i = tg;
    #1 check_eq({tag, ".cmd_ready"}, cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
    check_eq({tag, ".tok_send"}, tok_send_o, 1);
    check_eq({tag, ".tok_type"}, tok_type_o, t);
    check_eq({tag, ".tok_data"}, tok_data_o, exp_data);
    tick();
    check_eq({tag, ".tok_hold"}, tok_send_o, 1);
    tok_done_i = 1'b1;
    tick();
    tok_done_i = 1'b0;
    check_eq({tag, ".tok_drop"}, tok_send_o, 0);
  endtask

  // Send n payload bytes 11,22,.. through the passthrough, then report trn_tdone.
  task automatic tx_packet(input string tag, input logic [1:0] exp_tt, input int n);
    logic [7:0] b;
    check_eq({tag, ".tsend"}, trn_tsend_o, 1);
    check_eq({tag, ".ttype"}, trn_ttype_o, exp_tt);
    e_tready = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = 8'(8'h11 * (i + 1));
      s_tvalid = 1'b1; s_tdata = b; s_tlast = (i == n - 1);
      #1;
      check_eq({tag, ".e_tvalid"}, e_tvalid, 1);
      check_eq({tag, ".e_tdata"}, e_tdata, b);
      tick();
      if (i == 0) check_eq({tag, ".tsend_pulse"}, trn_tsend_o, 0);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    trn_tdone_i = 1'b1;
    tick();
    trn_tdone_i = 1'b0;
    e_tready = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [2:0] code, input int len);
    int k = 0;
    while (!rsp_valid_o && k < int'(TIMEOUT) + 50) begin
      tick();
      k++;
    end
    check_eq({tag, ".rsp_valid"}, rsp_valid_o, 1);
    check_eq({tag, ".rsp_code"}, rsp_code_o, code);
    check_eq({tag, ".rsp_len"}, rsp_len_o, len);
    tick();
    check_eq({tag, ".rsp_once"}, rsp_valid_o, 0);
    check_eq({tag, ".idle"}, cmd_ready_o, 1);
    check_eq({tag, ".code_hold"}, rsp_code_o, code);
  endtask

  // IN transfer receiving AA BB CC; crc_mode 0 none, 1 mid-packet, 2 cycle after tlast.
  task automatic in_xfer(input string tag, input logic tg, input logic [1:0] rtype,
                         input int crc_mode, input logic [2:0] exp_code);
    int idx = 0;
    int k = 0;
    int n_hsk = 0;
    start_cmd(tag, 2'b10, 7'd7, 4'd3, tg, 16'h0187);
    tick();
    dat_recv_i = 1'b1; dat_rtype_i = rtype;
    tick();
    dat_recv_i = 1'b0;
    while (idx < 3 && k < 40) begin
      d_tvalid = 1'b1; d_tdata = in_bytes[idx]; d_tlast = (idx == 2);
      m_tready = k[0];
      crc_err_i = (crc_mode == 1 && idx == 1);
      #1;
      check_eq({tag, ".m_tvalid"}, m_tvalid, 1);
      check_eq({tag, ".m_tdata"}, m_tdata, in_bytes[idx]);
      if (m_tready) idx++;
      tick();
      k++;
    end
    d_tvalid = 1'b0; d_tlast = 1'b0; m_tready = 1'b0;
    crc_err_i = (crc_mode == 2);
    k = 0;
    while (!rsp_valid_o && k < 20) begin
      #1;
      hsk_done_i = hsk_send_o;
      if (hsk_send_o) begin
        n_hsk++;
        check_eq({tag, ".hsk_type"}, hsk_type_o, 0);
      end
      tick();
      crc_err_i = 1'b0; hsk_done_i = 1'b0;
      k++;
    end
    check_eq({tag, ".n_hsk"}, n_hsk, (crc_mode == 0) ? 1 : 0);
    wait_rsp(tag, exp_code, 3);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    repeat (3) tick();
    check_eq("rst.cmd_ready", cmd_ready_o, 0);
    check_eq("rst.rsp_valid", rsp_valid_o, 0);
    check_eq("rst.tok_send", tok_send_o, 0);
    check_eq("rst.rsp_code", rsp_code_o, 0);
    check_eq("rst.rsp_len", rsp_len_o, 0);
    reset = 1'b1;
    #1 check_eq("rst.release_ready", cmd_ready_o, 1);
    tick();

    // OUT addr 5 ep 1 DATA1, 4 bytes, ACK ten cycles later; stray dat_recv ignored.
    start_cmd("out", 2'b00, 7'd5, 4'd1, 1'b1, 16'h0085);
    tx_packet("out", 2'b10, 4);
    dat_recv_i = 1'b1;
    repeat (9) tick();
    dat_recv_i = 1'b0;
    hsk_recv_i = 1'b1; hsk_rtype_i = 2'b00;
    tick();
    hsk_recv_i = 1'b0;
    wait_rsp("out", 3'd0, 4);

    // IN addr 3 ep 2, device NAKs; decoder stream must stay blocked.
    start_cmd("nak", 2'b10, 7'd3, 4'd2, 1'b0, 16'h0103);
    d_tvalid = 1'b1;
    repeat (3) begin
      #1;
      check_eq("nak.m_tvalid", m_tvalid, 0);
      check_eq("nak.hsk_send", hsk_send_o, 0);
      tick();
    end
    d_tvalid = 1'b0;
    hsk_recv_i = 1'b1; hsk_rtype_i = 2'b10;
    tick();
    hsk_recv_i = 1'b0;
    wait_rsp("nak", 3'd1, 0);

    in_xfer("in_d1", 1'b1, 2'b10, 0, 3'd0);
    in_xfer("in_seq", 1'b1, 2'b00, 0, 3'd6);
    in_xfer("crc_mid", 1'b0, 2'b00, 1, 3'd5);
    in_xfer("crc_late", 1'b0, 2'b00, 2, 3'd5);

    // SETUP with toggle=1 still sends DATA0; no reply -> TIMEOUT cycles after tdone.
    start_cmd("setup", 2'b11, 7'h10, 4'd0, 1'b1, 16'h0010);
    tx_packet("setup", 2'b00, 8);
    cyc = 0;
    while (!rsp_valid_o && cyc < int'(TIMEOUT) + 20) begin
      tick();
      cyc++;
    end
    check_eq("setup.timeout_cycles", cyc, TIMEOUT);
    wait_rsp("setup", 3'd4, 8);

    // Zero-length OUT; STALL arrives on the final allowed cycle and beats the timeout.
    start_cmd("zlp", 2'b00, 7'h7F, 4'hF, 1'b0, 16'h07FF);
    tx_packet("zlp", 2'b00, 0);
    repeat (TIMEOUT - 1) tick();
    hsk_recv_i = 1'b1; hsk_rtype_i = 2'b11;
    tick();
    hsk_recv_i = 1'b0;
    wait_rsp("zlp", 3'd2, 0);

    // Reserved token type.
    cmd_valid_i = 1'b1; cmd_type_i = 2'b01;
    tick();
    cmd_valid_i = 1'b0;
    check_eq("bad.tok_send", tok_send_o, 0);
    wait_rsp("bad", 3'd7, 0);

    // Reset while receiving IN data.
    start_cmd("rst_rx", 2'b10, 7'd1, 4'd0, 1'b0, 16'h0001);
    dat_recv_i = 1'b1; dat_rtype_i = 2'b00;
    tick();
    dat_recv_i = 1'b0;
    d_tvalid = 1'b1; d_tdata = 8'h5A; m_tready = 1'b1; s_tvalid = 1'b1; e_tready = 1'b1;
    #1 check_eq("rst_rx.m_tvalid_pre", m_tvalid, 1);
    reset = 1'b0;
    tick();
    check_eq("rst_rx.cmd_ready", cmd_ready_o, 0);
    check_eq("rst_rx.rsp_valid", rsp_valid_o, 0);
    check_eq("rst_rx.tok_send", tok_send_o, 0);
    check_eq("rst_rx.trn_tsend", trn_tsend_o, 0);
    check_eq("rst_rx.hsk_send", hsk_send_o, 0);
    check_eq("rst_rx.m_tvalid", m_tvalid, 0);
    check_eq("rst_rx.e_tvalid", e_tvalid, 0);
    check_eq("rst_rx.s_tready", s_tready, 0);
    check_eq("rst_rx.d_tready", d_tready, 0);
    check_eq("rst_rx.rsp_code", rsp_code_o, 0);
    check_eq("rst_rx.rsp_len", rsp_len_o, 0);
    reset = 1'b1;
    d_tvalid = 1'b0; m_tready = 1'b0; s_tvalid = 1'b0; e_tready = 1'b0;
    #1 check_eq("rst_rx.ready_after", cmd_ready_o, 1);
    repeat (3) begin
      tick();
      check_eq("rst_rx.no_stale_rsp", rsp_valid_o, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
